// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
    localparam logic [ADDR_W_DEF-1:0] NOP_REG   = '0;

    // Upper bounds for the generic match counter below; callers zero-extend
    // their packed vectors into these fixed-width containers.
    localparam int MAX_PORTS = 16;
    localparam int MAX_AW    = 8;

    typedef logic [MAX_PORTS*MAX_AW-1:0] addr_vec_t;
    typedef logic [MAX_PORTS-1:0]        en_vec_t;
    typedef logic [MAX_AW-1:0]           addr_t;
    typedef logic [7:0]                  match_cnt_t;

    // Number of enabled ports (out of nports, each aw bits wide) whose
    // address equals addr. Used for both reservation and commit counts.
    function automatic match_cnt_t count_matches(
        input addr_vec_t   addrs,
        input en_vec_t     en,
        input addr_t       addr,
        input int unsigned aw,
        input int unsigned nports
    );
        match_cnt_t n;
        addr_vec_t  sh;
        addr_t      mask;
        n    = '0;
        mask = addr_t'((9'd1 << aw) - 9'd1);
        for (int i = 0; i < MAX_PORTS; i++) begin
            sh = addrs >> (unsigned'(i) * aw);
            if ((unsigned'(i) < nports) && en[i] &&
                ((sh[MAX_AW-1:0] & mask) == (addr & mask)))
                n = n + 8'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between issue/writeback logic and the register file.
interface regfile_sb_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 2,
    parameter int NUM_ISS = 2
);
    logic [NUM_WR-1:0]         wr_en;
    logic [NUM_WR*ADDR_W-1:0]  wr_addr;
    logic [NUM_WR*DATA_W-1:0]  wr_data;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]         rd_busy;
    logic [NUM_ISS-1:0]        iss_en;
    logic [NUM_ISS*ADDR_W-1:0] iss_addr;
    logic                      flush;
    logic [ADDR_W-1:0]         dbg_addr;
    logic [DATA_W-1:0]         dbg_data;
    logic                      err_ovf;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush, dbg_addr,
        input  rd_data, rd_busy, dbg_data, err_ovf
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr, flush, dbg_addr,
        output rd_data, rd_busy, dbg_data, err_ovf
    );
endinterface

// File: rtl/regfile_sb_cnt.sv
// Per-register pending-write counter with saturating update.
module regfile_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W+1:0] ninc,
    input  logic [CNT_W+1:0] ndec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             ovf
);
    localparam int SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [SUM_W-1:0] sum;

    // Next count: flush wins, otherwise clamp cnt+ninc-ndec into range.
    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        sum   = $signed({2'b00, cnt_q}) + $signed(ninc) - $signed(ndec);
        if (flush) begin
            cnt_d = '0;
        end else if (sum < 0) begin
            cnt_d = '0;
        end else if (sum > CNT_MAX) begin
            cnt_d = '1;
            ovf   = 1'b1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Commits landing this cycle already retire their producer for readers.
    assign busy = ({2'b00, cnt_q} > ndec);
    assign cnt  = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-priority mux, read bypass,
// per-register pending counters and a registered debug port.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 2,
    parameter int NUM_ISS = 2,
    parameter int CNT_W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int SUM_W    = CNT_W + 2;
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(NOP_REG);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [DATA_W-1:0]   dbg_q, dbg_d;
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] busy_r, ovf_r;
    addr_vec_t           wr_addr_x, iss_addr_x;
    en_vec_t             wr_en_x, iss_en_x;

    // Widen the packed port vectors for the shared match counter.
    always_comb begin
        wr_addr_x  = '0;
        iss_addr_x = '0;
        wr_en_x    = '0;
        iss_en_x   = '0;
        wr_addr_x[NUM_WR*ADDR_W-1:0]   = bus.wr_addr;
        iss_addr_x[NUM_ISS*ADDR_W-1:0] = bus.iss_addr;
        wr_en_x[NUM_WR-1:0]            = bus.wr_en;
        iss_en_x[NUM_ISS-1:0]          = bus.iss_en;
    end

    assign busy_r[0] = 1'b0;
    assign ovf_r[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic [SUM_W-1:0] ninc_w, ndec_w;
        logic [CNT_W-1:0] cnt_w;
        assign ninc_w = SUM_W'(count_matches(iss_addr_x, iss_en_x, addr_t'(r), ADDR_W, NUM_ISS));
        assign ndec_w = SUM_W'(count_matches(wr_addr_x, wr_en_x, addr_t'(r), ADDR_W, NUM_WR));
        regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .ninc  (ninc_w),
            .ndec  (ndec_w),
            .flush (bus.flush),
            .cnt   (cnt_w),
            .busy  (busy_r[r]),
            .ovf   (ovf_r[r])
        );
    end

    // Write mux (later port overrides earlier), debug capture, sticky overflow.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] && (bus.wr_addr[i*ADDR_W +: ADDR_W] != R0))
                mem_d[bus.wr_addr[i*ADDR_W +: ADDR_W]] = bus.wr_data[i*DATA_W +: DATA_W];
        end
        dbg_d = mem_q[bus.dbg_addr];
        err_d = err_q | (|ovf_r);
    end

    // Storage, debug and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
            dbg_q <= '0;
            err_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            dbg_q <= dbg_d;
            err_q <= err_d;
        end
    end

    // Bypassed combinational reads; forced quiet while reset is held.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        ra          = '0;
        rv          = '0;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra = bus.rd_addr[j*ADDR_W +: ADDR_W];
            rv = mem_q[ra];
            for (int i = 0; i < NUM_WR; i++) begin
                if (bus.wr_en[i] && (bus.wr_addr[i*ADDR_W +: ADDR_W] == ra))
                    rv = bus.wr_data[i*DATA_W +: DATA_W];
            end
            if (rst && (ra != R0)) begin
                bus.rd_data[j*DATA_W +: DATA_W] = rv;
                bus.rd_busy[j]                  = busy_r[ra];
            end
        end
    end

    assign bus.dbg_data = dbg_q;
    assign bus.err_ovf  = err_q;

endmodule
